// File: rtl/lcd_char_buf.sv
// LCD character buffer: reset-to-fill storage, registered random-read port,
// dirty tracking and a valid/ready refresh scanner streaming entries in address order.
module lcd_char_buf #(
  parameter int unsigned       WIDTH  = 8,
  parameter int unsigned       DEPTH  = 32,
  parameter int unsigned       ADDR_W = 5,
  parameter logic [WIDTH-1:0]  FILL   = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              refresh,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              dirty
);

  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state;
  logic               pending;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               wr_ok;
  logic               rd_ok;
  logic               accept;
  logic               scan_start;
  logic [ADDR_W-1:0]  next_addr;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   next_idx;

  always_comb begin
    wr_ok      = wr_en && ({1'b0, wr_addr} < DEPTH_X);
    rd_ok      = ({1'b0, rd_addr} < DEPTH_X);
    accept     = out_valid && out_ready;
    next_addr  = out_addr + 1'b1;
    wr_idx     = wr_addr[IDX_W-1:0];
    rd_idx     = rd_addr[IDX_W-1:0];
    next_idx   = next_addr[IDX_W-1:0];
    // A scan starts from IDLE or restarts when the last beat is accepted with a request outstanding.
    scan_start = ((state == IDLE) && refresh) ||
                 ((state == SCAN) && accept && out_last && (pending || refresh));
  end

  // All mem reads below use the pre-edge contents, so same-cycle writes appear one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= FILL;
      rd_data   <= FILL;
      state     <= IDLE;
      pending   <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      dirty     <= 1'b0;
    end else begin
      if (wr_ok) mem[wr_idx] <= wr_data;
      rd_data <= rd_ok ? mem[rd_idx] : '0;

      if (wr_ok)           dirty <= 1'b1;
      else if (scan_start) dirty <= 1'b0;

      case (state)
        IDLE: begin
          if (refresh) begin
            state     <= SCAN;
            out_addr  <= '0;
            out_data  <= mem[0];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        SCAN: begin
          if (refresh) pending <= 1'b1;
          if (accept) begin
            if (out_last) begin
              pending  <= 1'b0;
              out_last <= 1'b0;
              if (pending || refresh) begin
                out_addr <= '0;
                out_data <= mem[0];
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
              end
            end else begin
              out_addr <= next_addr;
              out_data <= mem[next_idx];
              out_last <= (next_addr == LAST_A);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_buf.sv
// Self-checking bench for lcd_char_buf: vector table for write/read, reference model
// with read and beat scoreboards for scan, backpressure, pending and reset-abort cases.
module tb_lcd_char_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, refresh, out_ready;
  logic [4:0] wr_addr, rd_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data, out_data;
  logic [4:0] out_addr;
  logic       busy, out_valid, out_last, dirty;

  logic       w_wr_en;
  logic [5:0] w_wr_addr, w_rd_addr, w_out_addr;
  logic [7:0] w_wr_data, w_rd_data, w_out_data;
  logic       w_busy, w_out_valid, w_out_last, w_dirty;

  always #5 clk = ~clk;

  lcd_char_buf #(.WIDTH(8), .DEPTH(32), .ADDR_W(5), .FILL(8'h20)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .refresh(refresh), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .dirty(dirty)
  );

  lcd_char_buf #(.WIDTH(8), .DEPTH(32), .ADDR_W(6), .FILL(8'h20)) u_wide (
    .clk(clk), .rst_n(rst_n), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .rd_addr(w_rd_addr), .rd_data(w_rd_data), .refresh(1'b0), .busy(w_busy),
    .out_valid(w_out_valid), .out_ready(1'b0), .out_addr(w_out_addr),
    .out_data(w_out_data), .out_last(w_out_last), .dirty(w_dirty)
  );

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    bit         last;
  } beat_t;

  typedef struct {
    bit         we;
    logic [4:0] wa;
    logic [7:0] wd;
    logic [4:0] ra;
    logic [7:0] exp_rd;
    bit         exp_dirty;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         starts = 0;
  logic [7:0] mdl [32];
  bit         mdl_dirty, mdl_pend;
  beat_t      bq[$];
  logic [7:0] rq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: cycle budget expired (t=%0t)", nm, $time);
  endtask

  task automatic push_scan();
    for (int i = 0; i < 32; i++) begin
      beat_t b;
      b.a = 5'(i);
      b.d = mdl[i];
      b.last = (i == 31);
      bq.push_back(b);
    end
    starts++;
  endtask

  // Advances one clock: updates the model from the driven inputs, then checks every output.
  task automatic cycle();
    bit acc, start;
    acc = (out_valid === 1'b1) && (out_ready === 1'b1);
    start = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
      bq.delete();
      mdl_dirty = 1'b0;
      mdl_pend = 1'b0;
      rq.push_back(8'h20);
      acc = 1'b0;
    end else begin
      rq.push_back(mdl[rd_addr]);
      if (bq.size() == 0 && refresh) begin
        push_scan();
        start = 1'b1;
      end else begin
        if (refresh) mdl_pend = 1'b1;
        if (acc && bq.size() > 0 && bq[0].last && mdl_pend) begin
          push_scan();
          mdl_pend = 1'b0;
          start = 1'b1;
        end
      end
      if (wr_en) begin
        for (int i = 1 + int'(acc); i < bq.size(); i++)
          if (bq[i].a == wr_addr) bq[i].d = wr_data;
        mdl[wr_addr] = wr_data;
        mdl_dirty = 1'b1;
      end else if (start) begin
        mdl_dirty = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (acc && bq.size() > 0) void'(bq.pop_front());
    chk("rd_data", rd_data, rq.pop_front());
    chk("dirty", dirty, mdl_dirty);
    chk("busy", busy, bq.size() > 0);
    chk("out_valid", out_valid, bq.size() > 0);
    if (out_valid && bq.size() > 0) begin
      chk("out_addr", out_addr, bq[0].a);
      chk("out_data", out_data, bq[0].d);
      chk("out_last", out_last, bq[0].last);
    end else begin
      chk("out_last_idle", out_last, 1'b0);
    end
  endtask

  vec_t vt[6];

  initial begin
    int n;
    bit held_done, w20_done;

    vt[0] = '{we:1'b1, wa:5'd5,  wd:8'h41, ra:5'd5,  exp_rd:8'h20, exp_dirty:1'b1};
    vt[1] = '{we:1'b0, wa:5'd0,  wd:8'h00, ra:5'd5,  exp_rd:8'h41, exp_dirty:1'b1};
    vt[2] = '{we:1'b1, wa:5'd0,  wd:8'h7A, ra:5'd0,  exp_rd:8'h20, exp_dirty:1'b1};
    vt[3] = '{we:1'b1, wa:5'd31, wd:8'h55, ra:5'd0,  exp_rd:8'h7A, exp_dirty:1'b1};
    vt[4] = '{we:1'b0, wa:5'd0,  wd:8'h00, ra:5'd31, exp_rd:8'h55, exp_dirty:1'b1};
    vt[5] = '{we:1'b0, wa:5'd0,  wd:8'h00, ra:5'd6,  exp_rd:8'h20, exp_dirty:1'b1};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    refresh = 1'b0; out_ready = 1'b0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_addr = '0;

    // Reset for two cycles, then read every entry back.
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      cycle();
    end
    rd_addr = 5'd0;
    cycle();
    chk("reset_dirty", dirty, 1'b0);
    chk("reset_busy", busy, 1'b0);

    // Table-driven write/read vectors.
    for (int i = 0; i < 6; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd; rd_addr = vt[i].ra;
      cycle();
      chk("vec_rd", rd_data, vt[i].exp_rd);
      chk("vec_dirty", dirty, vt[i].exp_dirty);
    end
    wr_en = 1'b0;

    // Out-of-range write on the 6-bit address build.
    w_wr_en = 1'b1; w_wr_addr = 6'd40; w_wr_data = 8'h99; w_rd_addr = 6'd40;
    cycle();
    w_wr_en = 1'b0;
    cycle();
    chk("wide_rd_oob", w_rd_data, 8'h00);
    chk("wide_dirty_oob", w_dirty, 1'b0);
    w_rd_addr = 6'd8;
    cycle();
    chk("wide_rd_8", w_rd_data, 8'h20);
    w_wr_en = 1'b1; w_wr_addr = 6'd8; w_wr_data = 8'h11;
    cycle();
    w_wr_en = 1'b0;
    chk("wide_dirty_in", w_dirty, 1'b1);
    cycle();
    chk("wide_rd_new", w_rd_data, 8'h11);

    // Fill with addr+0x30, then a full scan with out_ready held high.
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 8'(i + 8'h30); rd_addr = 5'($urandom_range(0, 31));
      cycle();
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    refresh = 1'b1;
    cycle();
    refresh = 1'b0;
    n = 0;
    while (bq.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) timeout("full_scan");
    chk("scan_cycles", n, 32);
    chk("scan_dirty", dirty, 1'b0);

    // Random backpressure with writes to the held beat and to a later beat.
    held_done = 1'b0; w20_done = 1'b0;
    refresh = 1'b1;
    cycle();
    refresh = 1'b0;
    n = 0;
    while (bq.size() > 0 && n < 500) begin
      out_ready = 1'($urandom_range(0, 1));
      wr_en = 1'b0;
      if (out_valid && out_addr == 5'd10 && !w20_done) begin
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 8'hC3; w20_done = 1'b1;
      end else if (out_valid && !out_ready && !held_done) begin
        wr_en = 1'b1; wr_addr = out_addr; wr_data = 8'hEE; held_done = 1'b1;
      end
      cycle();
      n++;
    end
    wr_en = 1'b0;
    if (n >= 500) timeout("backpressure_scan");
    chk("mdl_addr20", mdl[20], 8'hC3);

    // Three refresh pulses mid-scan collapse into exactly one extra scan.
    out_ready = 1'b1;
    starts = 0;
    refresh = 1'b1;
    cycle();
    refresh = 1'b0;
    n = 0;
    while (bq.size() > 0 && n < 300) begin
      refresh = (n == 3 || n == 6 || n == 9);
      cycle();
      n++;
    end
    refresh = 1'b0;
    if (n >= 300) timeout("pending_scan");
    chk("pending_starts", starts, 2);
    chk("pending_cycles", n, 64);

    // Reset while beat 12 is presented.
    refresh = 1'b1;
    cycle();
    refresh = 1'b0;
    n = 0;
    while (!(out_valid && out_addr == 5'd12) && n < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    if (n >= 300) timeout("reach_addr12");
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      cycle();
    end
    cycle();
    chk("post_reset_rd31", rd_data, 8'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_char_buf.md
Name: lcd_char_buf

Overview:
Parametrised LCD character buffer. It succeeds the fixed 32x8 LCD register file and adds four things: synchronous reset-to-fill, a registered read port, a dirty flag, and a refresh scanner. The scanner streams every entry, in address order, to the LCD interface controller over a valid/ready handshake. It sits between the host-side character writer and the LCD driver FSM.

Parameters:
WIDTH, 8, bits per character entry
DEPTH, 32, number of entries (2..2**ADDR_W)
ADDR_W, 5, address width
FILL, 8'h20, reset value of every entry (ASCII space), WIDTH bits

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst_n  input  1  synchronous active-low reset
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
rd_addr  input  ADDR_W  random-read address
rd_data  output  WIDTH  registered read data
refresh  input  1  request a full scan-out
busy  output  1  scanner active
out_valid  output  1  scan beat valid
out_ready  input  1  downstream accepts beat
out_addr  output  ADDR_W  address of current beat
out_data  output  WIDTH  data of current beat
out_last  output  1  current beat is entry DEPTH-1
dirty  output  1  buffer written since last scan start

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge) causes all of the following in that single edge:
  - all entries become FILL;
  - rd_data=FILL;
  - scanner goes to IDLE;
  - busy=0, out_valid=0, out_addr=0, out_data=0, out_last=0, dirty=0;
  - the pending flag clears.
- Reset mid-scan aborts the scan with no further beats.
- Write:
  - When wr_en=1 and wr_addr<DEPTH, the entry is updated at the edge and dirty is set.
  - When wr_addr>=DEPTH, the write is ignored and dirty is unchanged.
- Read:
  - rd_data <= mem[rd_addr] each edge, so latency is 1 cycle.
  - When rd_addr>=DEPTH, rd_data <= 0.
  - A same-cycle write and read to the same address returns the OLD data; the new value appears the cycle after.
- Scanner states: IDLE, SCAN.
  - IDLE→SCAN when refresh=1. At that edge:
    - out_addr=0;
    - out_data=mem[0], pre-write value if address 0 is written in the same cycle;
    - out_valid=1, busy=1;
    - dirty cleared, unless a write lands in the same cycle, in which case dirty stays 1.
  - In SCAN, out_addr/out_data/out_last hold stable while out_valid=1 and out_ready=0.
  - A beat is accepted when out_valid && out_ready.
  - On acceptance of a non-last beat, out_addr increments and out_data loads mem[out_addr+1] at that edge, using the pre-write value under a same-cycle write.
  - out_last = out_valid && (out_addr==DEPTH-1).
  - On acceptance of the last beat: the scanner returns to IDLE with out_valid=0, busy=0, out_last=0; or restarts immediately at address 0 if pending=1, clearing pending.
- Writes during SCAN:
  - A write to the address currently held does not alter the presented beat.
  - A write to an address not yet presented is reflected when that beat loads.
- refresh while busy sets pending; multiple requests collapse into one.
- refresh in IDLE during reset is ignored.
- out_valid never drops without acceptance, except on reset.
- Throughput: one beat per cycle with out_ready held high, so a scan takes DEPTH cycles from the first out_valid to acceptance of the last beat.

Test Plan:
- Reset sequence: hold rst_n=0 for 2 cycles, then read addresses 0..31 → rd_data=8'h20 each, 1 cycle after the address; dirty=0, busy=0.
- Write then read: write addr 5=8'h41, same cycle rd_addr=5 → next-cycle rd_data=8'h20, following cycle 8'h41; dirty=1. Write addr 40 (DEPTH=32, ADDR_W=6 build) → ignored.
- Full scan, out_ready=1: after writing 0..31 with value addr+8'h30, pulse refresh → 32 consecutive beats, out_data=8'h30..8'h4F, out_last only on addr 31, busy falls the cycle after; dirty=0.
- Backpressure: toggle out_ready pseudo-randomly → no beat dropped or duplicated; out_data stable while stalled; writing the held address while stalled does not change out_data; writing addr 20 while at addr 10 → beat 20 shows the new value.
- Pending: pulse refresh three times mid-scan → exactly one extra scan follows, starting at addr 0 in the cycle after the last beat is accepted.
- Reset mid-scan at addr 12 with out_valid=1 → the next cycle has out_valid=0, busy=0, and all entries are 8'h20.
